control_unit_fsm: RTL and testbench

- Multi-cycle main control FSM of the 16-bit processor, directly upstream of the register file.
- Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK per instruction.
- Drives register-file controls (C_RegDstWrite, C_RegWrite, C_MemToReg) plus PC, IR, memory and ALU controls.
- Waits on a memory-ready handshake, with a timeout that halts the core on a stalled memory.

---
 rtl/cu_pkg.sv | 114 +++++++++++
 rtl/mem_wait_timer.sv | 29 ++
 rtl/control_unit_fsm.sv | 117 +++++++++++
 tb/tb_control_unit_fsm.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle control unit: states, opcodes, datapath select codes.
// ctrl_of() gives the Moore control word of a state. The gated FETCH writes are applied in the top.
package cu_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC_R = 4'd3,
    ST_WB_R   = 4'd4,
    ST_ADDR   = 4'd5,
    ST_MEM_LW = 4'd6,
    ST_WB_LW  = 4'd7,
    ST_MEM_SW = 4'd8,
    ST_BRANCH = 4'd9,
    ST_JUMP   = 4'd10,
    ST_HALT   = 4'd11
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_LW   = 4'h4;
  localparam logic [3:0] OP_SW   = 4'h5;
  localparam logic [3:0] OP_BEQ  = 4'h6;
  localparam logic [3:0] OP_J    = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_OFFS = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_dst_write;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

  function automatic ctrl_t ctrl_of(input state_e s, input logic [2:0] alu_fn);
    ctrl_t c;
    c = '0;
    case (s)
      ST_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_ONE;
        c.alu_op    = ALU_ADD;
        c.pc_source = PCS_ALU;
      end
      ST_DECODE: begin
        c.alu_src_b = SRCB_OFFS;
        c.alu_op    = ALU_ADD;
      end
      ST_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = alu_fn;
      end
      ST_WB_R: begin
        c.reg_write     = 1'b1;
        c.reg_dst_write = 1'b1;
      end
      ST_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_OFFS;
        c.alu_op    = ALU_ADD;
      end
      ST_MEM_LW: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      ST_WB_LW: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      ST_MEM_SW: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      ST_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_B;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCS_ALUOUT;
      end
      ST_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCS_JUMP;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready memory cycles. timeout is combinational and flags the MEM_TIMEOUT-th stall.
// clear has priority over enable. The count saturates at the timeout point.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic timeout
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  assign timeout = enable && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !timeout) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/control_unit_fsm.sv
// Multi-cycle main control FSM. Controls are registered from the next state, so they line up with O_State.
// FETCH IR/PC writes wait on I_MemReady. A stalled memory access halts the core after MEM_TIMEOUT cycles.
module control_unit_fsm
  import cu_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] I_Opcode,
  input  logic                I_Zero,
  input  logic                I_MemReady,
  output logic                C_PCWrite,
  output logic                C_PCWriteCond,
  output logic [1:0]          C_PCSource,
  output logic                C_IorD,
  output logic                C_MemRead,
  output logic                C_MemWrite,
  output logic                C_IRWrite,
  output logic                C_ALUSrcA,
  output logic [1:0]          C_ALUSrcB,
  output logic [2:0]          C_ALUOp,
  output logic                C_RegDstWrite,
  output logic                C_RegWrite,
  output logic                C_MemToReg,
  output logic [3:0]          O_State,
  output logic                O_Halted,
  output logic                O_Error
);

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;
  ctrl_t      ctrl_q;
  logic       halted_q, err_q;
  logic       mem_st, timeout, opc_fetch;
  logic [3:0] opc;
  logic       zero_unused;

  // The zero flag qualifies C_PCWriteCond in the datapath. It is not consumed here.
  assign zero_unused = I_Zero;
  assign opc         = 4'(I_Opcode);
  assign mem_st      = (state_q == ST_FETCH) || (state_q == ST_MEM_LW) || (state_q == ST_MEM_SW);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .enable  (mem_st && !I_MemReady),
    .clear   (I_MemReady || (state_d != state_q)),
    .timeout (timeout)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH:  if (I_MemReady) state_d = ST_DECODE; else if (timeout) state_d = ST_HALT;
      ST_DECODE: begin
        op_d = opc;
        case (opc)
          OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = ST_EXEC_R;
          OP_LW, OP_SW:                  state_d = ST_ADDR;
          OP_BEQ:                        state_d = ST_BRANCH;
          OP_J:                          state_d = ST_JUMP;
          OP_HALT:                       state_d = ST_HALT;
          default:                       state_d = ST_FETCH;
        endcase
      end
      ST_EXEC_R: state_d = ST_WB_R;
      ST_WB_R:   state_d = ST_FETCH;
      ST_ADDR:   state_d = (op_q == OP_LW) ? ST_MEM_LW : ST_MEM_SW;
      ST_MEM_LW: if (I_MemReady) state_d = ST_WB_LW; else if (timeout) state_d = ST_HALT;
      ST_WB_LW:  state_d = ST_FETCH;
      ST_MEM_SW: if (I_MemReady) state_d = ST_FETCH; else if (timeout) state_d = ST_HALT;
      ST_BRANCH: state_d = ST_FETCH;
      ST_JUMP:   state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      ctrl_q   <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ctrl_q   <= ctrl_of(state_d, op_d[2:0]);
      halted_q <= (state_d == ST_HALT);
      if (timeout) err_q <= 1'b1;
    end
  end

  assign opc_fetch     = (state_q == ST_FETCH) && I_MemReady;
  assign C_PCWrite     = ctrl_q.pc_write || opc_fetch;
  assign C_IRWrite     = opc_fetch;
  assign C_PCWriteCond = ctrl_q.pc_write_cond;
  assign C_PCSource    = ctrl_q.pc_source;
  assign C_IorD        = ctrl_q.iord;
  assign C_MemRead     = ctrl_q.mem_read;
  assign C_MemWrite    = ctrl_q.mem_write;
  assign C_ALUSrcA     = ctrl_q.alu_src_a;
  assign C_ALUSrcB     = ctrl_q.alu_src_b;
  assign C_ALUOp       = ctrl_q.alu_op;
  assign C_RegDstWrite = ctrl_q.reg_dst_write;
  assign C_RegWrite    = ctrl_q.reg_write;
  assign C_MemToReg    = ctrl_q.mem_to_reg;
  assign O_State       = state_q;
  assign O_Halted      = halted_q;
  assign O_Error       = err_q;

endmodule

// File: tb/tb_control_unit_fsm.sv
// Directed bench for control_unit_fsm: vector table for instruction flows, hand sequences for timeout/halt/reset.
module tb_control_unit_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] op  = 4'h0;
  logic       zero = 1'b0;
  logic       rdy = 1'b1;

  logic       C_PCWrite, C_PCWriteCond, C_IorD, C_MemRead, C_MemWrite, C_IRWrite;
  logic       C_ALUSrcA, C_RegDstWrite, C_RegWrite, C_MemToReg, O_Halted, O_Error;
  logic [1:0] C_PCSource, C_ALUSrcB;
  logic [2:0] C_ALUOp;
  logic [3:0] O_State;

  always #5 clk = ~clk;

  control_unit_fsm #(.OPCODE_W(4), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .I_Opcode(op), .I_Zero(zero), .I_MemReady(rdy),
    .C_PCWrite(C_PCWrite), .C_PCWriteCond(C_PCWriteCond), .C_PCSource(C_PCSource),
    .C_IorD(C_IorD), .C_MemRead(C_MemRead), .C_MemWrite(C_MemWrite), .C_IRWrite(C_IRWrite),
    .C_ALUSrcA(C_ALUSrcA), .C_ALUSrcB(C_ALUSrcB), .C_ALUOp(C_ALUOp),
    .C_RegDstWrite(C_RegDstWrite), .C_RegWrite(C_RegWrite), .C_MemToReg(C_MemToReg),
    .O_State(O_State), .O_Halted(O_Halted), .O_Error(O_Error)
  );

  // {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, ALUSrcB, ALUOp, RegDst, RegWrite, MemToReg}
  logic [16:0] act_ctl;
  assign act_ctl = {C_PCWrite, C_PCWriteCond, C_PCSource, C_IorD, C_MemRead, C_MemWrite, C_IRWrite,
                    C_ALUSrcA, C_ALUSrcB, C_ALUOp, C_RegDstWrite, C_RegWrite, C_MemToReg};

  localparam logic [16:0] K_ZERO   = 17'b0_0_00_0_0_0_0_0_00_000_0_0_0;
  localparam logic [16:0] K_FETCHR = 17'b1_0_00_0_1_0_1_0_01_000_0_0_0;
  localparam logic [16:0] K_FETCHS = 17'b0_0_00_0_1_0_0_0_01_000_0_0_0;
  localparam logic [16:0] K_DEC    = 17'b0_0_00_0_0_0_0_0_10_000_0_0_0;
  localparam logic [16:0] K_EXADD  = 17'b0_0_00_0_0_0_0_1_00_000_0_0_0;
  localparam logic [16:0] K_EXSUB  = 17'b0_0_00_0_0_0_0_1_00_001_0_0_0;
  localparam logic [16:0] K_EXOR   = 17'b0_0_00_0_0_0_0_1_00_011_0_0_0;
  localparam logic [16:0] K_WBR    = 17'b0_0_00_0_0_0_0_0_00_000_1_1_0;
  localparam logic [16:0] K_ADDR   = 17'b0_0_00_0_0_0_0_1_10_000_0_0_0;
  localparam logic [16:0] K_MLW    = 17'b0_0_00_1_1_0_0_0_00_000_0_0_0;
  localparam logic [16:0] K_WBLW   = 17'b0_0_00_0_0_0_0_0_00_000_0_1_1;
  localparam logic [16:0] K_MSW    = 17'b0_0_00_1_0_1_0_0_00_000_0_0_0;
  localparam logic [16:0] K_BR     = 17'b0_1_01_0_0_0_0_1_00_001_0_0_0;
  localparam logic [16:0] K_J      = 17'b1_0_10_0_0_0_0_0_00_000_0_0_0;

  typedef struct {
    logic        rst_n;
    logic [3:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic        halted;
    logic        err;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk_out(input string n, input logic [3:0] st, input logic [16:0] ctl,
                         input logic h, input logic e);
    chk({n, "_state"}, 32'(O_State), 32'(st));
    chk({n, "_ctl"}, 32'(act_ctl), 32'(ctl));
    chk({n, "_halted"}, 32'(O_Halted), 32'(h));
    chk({n, "_error"}, 32'(O_Error), 32'(e));
    chk({n, "_rd_and_wr"}, 32'(C_MemRead & C_MemWrite), 32'd0);
  endtask

  task automatic add(input logic r, input logic [3:0] o, input logic y, input logic [3:0] s,
                     input logic [16:0] c, input logic h, input logic e);
    vec_t v;
    v.rst_n = r; v.op = o; v.rdy = y; v.st = s; v.ctl = c; v.halted = h; v.err = e;
    tbl.push_back(v);
  endtask

  task automatic nxt;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the FSM in FETCH at a negedge, with rdy=1.
  task automatic do_reset;
    rst = 1'b0; rdy = 1'b1; op = 4'h0;
    #1;
    chk_out("rst", 4'd0, K_ZERO, 1'b0, 1'b0);
    nxt;
    rst = 1'b1;
    nxt;
  endtask

  task automatic stall_run(input logic ready_on_15);
    do_reset;
    for (int i = 0; i < 14; i++) begin
      rdy = 1'b0;
      #1;
      chk($sformatf("stall%0d_state", i), 32'(O_State), 32'd1);
      chk($sformatf("stall%0d_error", i), 32'(O_Error), 32'd0);
      nxt;
    end
    rdy = ready_on_15;
    #1;
    nxt;
    rdy = 1'b0;
    #1;
    if (ready_on_15) chk_out("rdy15", 4'd2, K_DEC, 1'b0, 1'b0);
    else             chk_out("tmo", 4'd11, K_ZERO, 1'b1, 1'b1);
    nxt;
    #1;
    if (!ready_on_15) chk_out("tmo_hold", 4'd11, K_ZERO, 1'b1, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    add(0, 4'h0, 1, 4'd0,  K_ZERO,   0, 0);
    add(1, 4'h0, 1, 4'd0,  K_ZERO,   0, 0);
    add(1, 4'h0, 1, 4'd1,  K_FETCHR, 0, 0);
    add(1, 4'h0, 1, 4'd2,  K_DEC,    0, 0);
    add(1, 4'h0, 1, 4'd3,  K_EXADD,  0, 0);
    add(1, 4'h0, 1, 4'd4,  K_WBR,    0, 0);
    add(1, 4'h3, 1, 4'd1,  K_FETCHR, 0, 0);
    add(1, 4'h3, 1, 4'd2,  K_DEC,    0, 0);
    add(1, 4'h3, 1, 4'd3,  K_EXOR,   0, 0);
    add(1, 4'h3, 1, 4'd4,  K_WBR,    0, 0);
    add(1, 4'h4, 1, 4'd1,  K_FETCHR, 0, 0);
    add(1, 4'h4, 1, 4'd2,  K_DEC,    0, 0);
    add(1, 4'h4, 1, 4'd5,  K_ADDR,   0, 0);
    add(1, 4'h4, 0, 4'd6,  K_MLW,    0, 0);
    add(1, 4'h4, 0, 4'd6,  K_MLW,    0, 0);
    add(1, 4'h4, 0, 4'd6,  K_MLW,    0, 0);
    add(1, 4'h4, 1, 4'd6,  K_MLW,    0, 0);
    add(1, 4'h4, 1, 4'd7,  K_WBLW,   0, 0);
    add(1, 4'h5, 1, 4'd1,  K_FETCHR, 0, 0);
    add(1, 4'h5, 1, 4'd2,  K_DEC,    0, 0);
    add(1, 4'h5, 1, 4'd5,  K_ADDR,   0, 0);
    add(1, 4'h5, 1, 4'd8,  K_MSW,    0, 0);
    add(1, 4'h6, 1, 4'd1,  K_FETCHR, 0, 0);
    add(1, 4'h6, 1, 4'd2,  K_DEC,    0, 0);
    add(1, 4'h6, 1, 4'd9,  K_BR,     0, 0);
    add(1, 4'h7, 1, 4'd1,  K_FETCHR, 0, 0);
    add(1, 4'h7, 1, 4'd2,  K_DEC,    0, 0);
    add(1, 4'h7, 1, 4'd10, K_J,      0, 0);
    add(1, 4'hA, 1, 4'd1,  K_FETCHR, 0, 0);
    add(1, 4'hA, 1, 4'd2,  K_DEC,    0, 0);
    add(1, 4'h1, 1, 4'd1,  K_FETCHR, 0, 0);
    add(1, 4'h1, 1, 4'd2,  K_DEC,    0, 0);
    add(1, 4'h1, 1, 4'd3,  K_EXSUB,  0, 0);
    add(1, 4'h1, 1, 4'd4,  K_WBR,    0, 0);
    add(1, 4'h1, 0, 4'd1,  K_FETCHS, 0, 0);

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst_n;
      op  = tbl[i].op;
      rdy = tbl[i].rdy;
      #1;
      chk_out($sformatf("vec%0d", i), tbl[i].st, tbl[i].ctl, tbl[i].halted, tbl[i].err);
      nxt;
    end

    stall_run(1'b0);
    stall_run(1'b1);

    // HALT opcode: held with no controls until reset, no error flag.
    do_reset;
    nxt;
    op = 4'hF;
    nxt;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk_out($sformatf("halt%0d", i), 4'd11, K_ZERO, 1'b1, 1'b0);
      nxt;
    end

    // Asynchronous reset in the middle of a stalled store.
    do_reset;
    nxt;
    op = 4'h5;
    nxt;
    rdy = 1'b0;
    nxt;
    #1;
    chk_out("sw_pre", 4'd8, K_MSW, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk_out("sw_arst", 4'd0, K_ZERO, 1'b0, 1'b0);
    rdy = 1'b1;
    nxt;
    rst = 1'b1;
    #1;
    chk_out("arst_idle", 4'd0, K_ZERO, 1'b0, 1'b0);
    nxt;
    #1;
    chk_out("arst_fetch", 4'd1, K_FETCHR, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
